serial_magnitude_comparator: RTL and testbench

SERIAL_MAGNITUDE_COMPARATOR -- requirements
Module: serial_magnitude_comparator

---
 rtl/serial_magnitude_comparator.sv | 110 +++++++++++
 tb/tb_serial_magnitude_comparator.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//   Compares two WIDTH-bit operands DIGIT bits per clock, most significant
//   digit first, and stops as soon as a differing digit is found.
//   Signed operands are handled by flipping the sign bit at capture time,
//   which maps two's-complement ordering onto unsigned ordering.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request a comparison (accepted when not busy)
//   signed_mode  1 = two's-complement, 0 = unsigned; sampled with start
//   a, b         operands, sampled with start
//   busy         high while digits are being compared
//   done         one-cycle pulse when gt/eq/lt become valid
//   gt, eq, lt   result flags, held until the next accepted start
//   state_dbg    current FSM state (IDLE=0, RUN=1, DONE=2)
//
// Handshake: start is a single-cycle request. It is accepted on a rising
// edge whenever busy is low (IDLE or DONE); while busy is high it is ignored.
// There is no separate ready signal: busy low means the next start is taken.

module serial_magnitude_comparator #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt,
    output logic [1:0]       state_dbg
);

    localparam int D     = WIDTH / DIGIT;
    localparam int IDX_W = (D > 1) ? $clog2(D) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(D - 1);
    localparam logic [WIDTH-1:0] SIGN_BIT = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [DIGIT-1:0] a_dig;
    logic [DIGIT-1:0] b_dig;

    // Digit under comparison this cycle.
    assign a_dig = a_q[idx*DIGIT +: DIGIT];
    assign b_dig = b_q[idx*DIGIT +: DIGIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // Flipping the sign bit turns signed order into unsigned order.
                        a_q   <= signed_mode ? (a ^ SIGN_BIT) : a;
                        b_q   <= signed_mode ? (b ^ SIGN_BIT) : b;
                        gt    <= 1'b0;
                        eq    <= 1'b0;
                        lt    <= 1'b0;
                        idx   <= TOP_IDX;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (a_dig != b_dig) begin
                        // First differing digit decides the result.
                        gt    <= (a_dig > b_dig);
                        lt    <= (a_dig < b_dig);
                        state <= DONE;
                    end else if (idx == '0) begin
                        eq    <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx - IDX_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign state_dbg = state;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
module tb_serial_magnitude_comparator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 8/2 ----------------
  logic       start8 = 1'b0, m8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, gt8, eq8, lt8;
  logic [1:0] st8;

  serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(m8),
    .a(a8), .b(b8), .busy(busy8), .done(done8),
    .gt(gt8), .eq(eq8), .lt(lt8), .state_dbg(st8)
  );

  // ---------------- DUT 16/4 ----------------
  logic        start16 = 1'b0, m16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, gt16, eq16, lt16;
  logic [1:0]  st16;

  serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .signed_mode(m16),
    .a(a16), .b(b16), .busy(busy16), .done(done16),
    .gt(gt16), .eq(eq16), .lt(lt16), .state_dbg(st16)
  );

  // ---------------- scoreboard ----------------
  // entry = {expected busy cycles[12:0], gt, eq, lt}
  logic [15:0] exp8_q[$];
  logic [15:0] exp16_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int bc8 = 0;
  int bc16 = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: flags from a plain (signed or unsigned) compare; busy cycles
  // = position of first differing digit from the top + 1, or D if equal.
  function automatic logic [15:0] model(input int w, input int dg,
                                        input logic [15:0] av, input logic [15:0] bv,
                                        input logic m);
    int sa, sb, nd, lat, sh;
    logic [15:0] xa, xb, msk;
    logic g, e, l;
    sa = int'(av);
    sb = int'(bv);
    if (m) begin
      if (av[w-1]) sa = sa - (1 << w);
      if (bv[w-1]) sb = sb - (1 << w);
    end
    g = (sa > sb);
    e = (sa == sb);
    l = (sa < sb);
    xa = m ? (av ^ (16'h1 << (w - 1))) : av;
    xb = m ? (bv ^ (16'h1 << (w - 1))) : bv;
    msk = 16'((1 << dg) - 1);
    nd = w / dg;
    lat = nd;
    for (int j = nd - 1; j >= 0; j--) begin
      sh = (nd - 1 - j) * dg;
      if (((xa >> sh) & msk) != ((xb >> sh) & msk)) lat = j + 1;
    end
    return {lat[12:0], g, e, l};
  endfunction

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst_n) begin
      bc8 = 0;
    end else begin
      if (busy8) bc8++;
      if (done8) begin
        chk("dut8_result_expected", (exp8_q.size() != 0), 1);
        chk("dut8_onehot", $countones({gt8, eq8, lt8}), 1);
        if (exp8_q.size() != 0) begin
          e = exp8_q.pop_front();
          chk("dut8_flags", {gt8, eq8, lt8}, e[2:0]);
          chk("dut8_busy_cycles", bc8, e[15:3]);
        end
        bc8 = 0;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst_n) begin
      bc16 = 0;
    end else begin
      if (busy16) bc16++;
      if (done16) begin
        chk("dut16_result_expected", (exp16_q.size() != 0), 1);
        chk("dut16_onehot", $countones({gt16, eq16, lt16}), 1);
        if (exp16_q.size() != 0) begin
          e = exp16_q.pop_front();
          chk("dut16_flags", {gt16, eq16, lt16}, e[2:0]);
          chk("dut16_busy_cycles", bc16, e[15:3]);
        end
        bc16 = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Drive a start for one cycle; afterwards scramble the inputs so a design
  // that keeps sampling them after acceptance gets caught.
  task automatic apply(input bit wide, input logic [15:0] av, input logic [15:0] bv,
                       input logic m, input bit push);
    if (wide) begin
      a16 = av; b16 = bv; m16 = m; start16 = 1'b1;
      if (push) exp16_q.push_back(model(16, 4, av, bv, m));
    end else begin
      a8 = av[7:0]; b8 = bv[7:0]; m8 = m; start8 = 1'b1;
      if (push) exp8_q.push_back(model(8, 2, {8'h00, av[7:0]}, {8'h00, bv[7:0]}, m));
    end
    @(posedge clk);
    #1;
    start8 = 1'b0;
    start16 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); m8 = 1'($urandom_range(0, 1));
    a16 = 16'($urandom); b16 = 16'($urandom); m16 = 1'($urandom_range(0, 1));
  endtask

  // Returns at the negedge where done is seen; bounded.
  task automatic wait_done(input bit wide, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = wide ? done16 : done8;
    end
    chk(tag, seen, 1);
  endtask

  function automatic logic [15:0] pick_b(input logic [15:0] av, input int w);
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return av;
    if (r == 1) return av ^ (16'h1 << $urandom_range(0, w - 1));
    return 16'($urandom);
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [15:0] ra, rb;

    // reset state
    #1;
    chk("reset_dut8_outputs", {busy8, done8, gt8, eq8, lt8}, 5'b0);
    chk("reset_dut8_state", st8, 2'd0);
    chk("reset_dut16_outputs", {busy16, done16, gt16, eq16, lt16}, 5'b0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    // equal operands: full-length compare
    @(negedge clk);
    apply(0, 16'h5A, 16'h5A, 0, 1);
    wait_done(0, "r026_done_seen");
    chk("r026_flags", {gt8, eq8, lt8}, 3'b010);
    @(negedge clk);
    chk("r026_hold_flags", {gt8, eq8, lt8}, 3'b010);
    chk("r026_back_to_idle", st8, 2'd0);
    chk("r026_done_pulse", done8, 1'b0);

    // unsigned vs signed on the same operands
    @(negedge clk);
    apply(0, 16'hC0, 16'h3F, 0, 1);
    wait_done(0, "r027u_done_seen");
    chk("r027u_flags", {gt8, eq8, lt8}, 3'b100);
    @(negedge clk);
    apply(0, 16'hC0, 16'h3F, 1, 1);
    wait_done(0, "r027s_done_seen");
    chk("r027s_flags", {gt8, eq8, lt8}, 3'b001);

    // back-to-back start in the DONE cycle
    @(negedge clk);
    apply(0, 16'h12, 16'h13, 0, 1);
    wait_done(0, "r028a_done_seen");
    chk("r028a_flags", {gt8, eq8, lt8}, 3'b001);
    apply(0, 16'hFF, 16'h00, 0, 1);
    chk("r028_no_idle_gap", busy8, 1'b1);
    chk("r028_flags_cleared", {gt8, eq8, lt8}, 3'b000);
    wait_done(0, "r028b_done_seen");
    chk("r028b_flags", {gt8, eq8, lt8}, 3'b100);

    // start during RUN is ignored
    @(negedge clk);
    apply(0, 16'h01, 16'h02, 0, 1);
    @(negedge clk);
    apply(0, 16'hFF, 16'h02, 0, 0);
    wait_done(0, "r029_done_seen");
    chk("r029_flags", {gt8, eq8, lt8}, 3'b001);

    // asynchronous reset mid-RUN, then a normal compare
    @(negedge clk);
    apply(0, 16'h00, 16'h00, 0, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r030_async_outputs", {busy8, done8, gt8, eq8, lt8}, 5'b0);
    chk("r030_async_state", st8, 2'd0);
    @(negedge clk);
    @(negedge clk);
    chk("r030_no_done_in_reset", done8, 1'b0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    apply(0, 16'h80, 16'h80, 0, 1);
    wait_done(0, "r030_done_seen");
    chk("r030_flags", {gt8, eq8, lt8}, 3'b010);

    // 16-bit, 4-bit digits
    @(negedge clk);
    apply(1, 16'h1234, 16'h1244, 0, 1);
    wait_done(1, "r031_done_seen");
    chk("r031_flags", {gt16, eq16, lt16}, 3'b001);
    chk("r031_dut8_quiet", st8, 2'd0);

    // random back-to-back sweep, 16/4, both modes
    for (int i = 0; i < 10000; i++) begin
      ra = 16'($urandom);
      rb = pick_b(ra, 16);
      apply(1, ra, rb, 1'(i % 2), 1);
      wait_done(1, "rand16_done_seen");
    end

    // random sweep, 8/2
    @(negedge clk);
    for (int i = 0; i < 500; i++) begin
      ra = {8'h00, 8'($urandom)};
      rb = {8'h00, pick_b(ra, 8) & 16'h00FF};
      apply(0, ra, rb, 1'($urandom_range(0, 1)), 1);
      wait_done(0, "rand8_done_seen");
    end

    @(negedge clk);
    @(negedge clk);
    chk("dut8_queue_drained", exp8_q.size(), 0);
    chk("dut16_queue_drained", exp16_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
